// File: rtl/kanagawa_sim_stall_monitor_if.sv
// Stall line plus completed-run report between a stall source and the monitor.
// The master drives the stall line and observes reports; the monitor is the slave.
interface kanagawa_sim_stall_monitor_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   stalled_in;
  logic                   run_valid;
  logic                   run_is_stall;
  logic [COUNT_WIDTH-1:0] run_len;

  modport master (
    output stalled_in,
    input  run_valid,
    input  run_is_stall,
    input  run_len
  );

  modport slave (
    input  stalled_in,
    output run_valid,
    output run_is_stall,
    output run_len
  );
endinterface

// File: rtl/kanagawa_sim_stall_monitor.sv
// Stall-line monitor: splits the sampled stall line into stalled and free runs,
// reports each completed run, keeps saturating statistics and raises sticky
// errors when run lengths leave the configured bounds.
module kanagawa_sim_stall_monitor #(
  parameter int COUNT_WIDTH  = 16,
  parameter int MIN_DURATION = 1,
  parameter int MAX_DURATION = 64,
  parameter int MIN_INTERVAL = 1,
  parameter int MAX_INTERVAL = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  kanagawa_sim_stall_monitor_if.slave stall_if,
  output logic [COUNT_WIDTH-1:0] burst_count,
  output logic [COUNT_WIDTH-1:0] stall_cycles,
  output logic [COUNT_WIDTH-1:0] max_duration_seen,
  output logic                   duration_err,
  output logic                   interval_err
);

  typedef enum logic [2:0] {
    IDLE,
    STALL_PARTIAL,
    FREE_PARTIAL,
    STALL_FULL,
    FREE_FULL
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  // A bound at or above the saturation value can never be exceeded by a
  // saturating length, so its overrun check is compiled out.
  localparam bit DUR_OVR_EN = (MAX_DURATION < (2 ** COUNT_WIDTH) - 1);
  localparam bit INT_OVR_EN = (MAX_INTERVAL < (2 ** COUNT_WIDTH) - 1);
  localparam logic [COUNT_WIDTH-1:0] DUR_LIMIT = DUR_OVR_EN ? COUNT_WIDTH'(MAX_DURATION) : '0;
  localparam logic [COUNT_WIDTH-1:0] INT_LIMIT = INT_OVR_EN ? COUNT_WIDTH'(MAX_INTERVAL) : '0;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cur_len_q, cur_len_d;
  logic                   run_valid_q, run_valid_d;
  logic                   run_is_stall_q, run_is_stall_d;
  logic [COUNT_WIDTH-1:0] run_len_q, run_len_d;
  logic [COUNT_WIDTH-1:0] burst_count_q, burst_count_d;
  logic [COUNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [COUNT_WIDTH-1:0] max_seen_q, max_seen_d;
  logic                   duration_err_q, duration_err_d;
  logic                   interval_err_q, interval_err_d;
  logic                   cur_level;
  logic                   is_full;

  // Next-state and next-statistics computation for one stall-line sample.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d        = state_q;
    cur_len_d      = cur_len_q;
    run_valid_d    = 1'b0;
    run_is_stall_d = run_is_stall_q;
    run_len_d      = run_len_q;
    burst_count_d  = burst_count_q;
    stall_cycles_d = stall_cycles_q;
    max_seen_d     = max_seen_q;
    duration_err_d = duration_err_q;
    interval_err_d = interval_err_q;
    cur_level      = (state_q == STALL_PARTIAL) || (state_q == STALL_FULL);
    is_full        = (state_q == STALL_FULL) || (state_q == FREE_FULL);

    if (clear) begin
      // Clear wins over everything, including a run completing this cycle.
      state_d        = IDLE;
      cur_len_d      = '0;
      burst_count_d  = '0;
      stall_cycles_d = '0;
      max_seen_d     = '0;
      duration_err_d = 1'b0;
      interval_err_d = 1'b0;
    end else if (!enable) begin
      // An interrupted run is dropped; statistics and errors hold.
      state_d   = IDLE;
      cur_len_d = '0;
    end else begin
      if (stall_if.stalled_in) begin
        stall_cycles_d = sat_inc(stall_cycles_q);
      end

      if (state_q == IDLE) begin
        // First sample: the run's true start is unknown, so it is partial.
        cur_len_d = CNT_ONE;
        state_d   = stall_if.stalled_in ? STALL_PARTIAL : FREE_PARTIAL;
      end else if (stall_if.stalled_in == cur_level) begin
        // Same level: extend the run and flag an overrun the moment it happens.
        cur_len_d = sat_inc(cur_len_q);
        if (cur_level && DUR_OVR_EN && (cur_len_q == DUR_LIMIT)) begin
          duration_err_d = 1'b1;
        end
        if (!cur_level && INT_OVR_EN && (cur_len_q == INT_LIMIT)) begin
          interval_err_d = 1'b1;
        end
      end else begin
        // Level change: the current run ends; the next one has a known start.
        cur_len_d = CNT_ONE;
        state_d   = stall_if.stalled_in ? STALL_FULL : FREE_FULL;
        if (is_full) begin
          run_valid_d    = 1'b1;
          run_is_stall_d = cur_level;
          run_len_d      = cur_len_q;
          if (cur_level) begin
            burst_count_d = sat_inc(burst_count_q);
            if (cur_len_q > max_seen_q) begin
              max_seen_d = cur_len_q;
            end
            if (64'(cur_len_q) < 64'(MIN_DURATION)) begin
              duration_err_d = 1'b1;
            end
          end else if (64'(cur_len_q) < 64'(MIN_INTERVAL)) begin
            interval_err_d = 1'b1;
          end
        end
      end
    end
  end

  // State, run tracking and registered outputs, with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cur_len_q      <= '0;
      run_valid_q    <= 1'b0;
      run_is_stall_q <= 1'b0;
      run_len_q      <= '0;
      burst_count_q  <= '0;
      stall_cycles_q <= '0;
      max_seen_q     <= '0;
      duration_err_q <= 1'b0;
      interval_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q        <= state_d;
      cur_len_q      <= cur_len_d;
      run_valid_q    <= run_valid_d;
      run_is_stall_q <= run_is_stall_d;
      run_len_q      <= run_len_d;
      burst_count_q  <= burst_count_d;
      stall_cycles_q <= stall_cycles_d;
      max_seen_q     <= max_seen_d;
      duration_err_q <= duration_err_d;
      interval_err_q <= interval_err_d;
    end
  end

  assign stall_if.run_valid    = run_valid_q;
  assign stall_if.run_is_stall = run_is_stall_q;
  assign stall_if.run_len      = run_len_q;
  assign burst_count           = burst_count_q;
  assign stall_cycles          = stall_cycles_q;
  assign max_duration_seen     = max_seen_q;
  assign duration_err          = duration_err_q;
  assign interval_err          = interval_err_q;

endmodule

// File: tb/tb_kanagawa_sim_stall_monitor.sv
// Directed bench for the stall monitor. Three instances share one stall line:
// u0 uses default bounds, u1 a tight policy, u2 a 4-bit counter width.
module tb_kanagawa_sim_stall_monitor;

  logic clk;
  logic rst;
  logic en;
  logic clr;
  logic stall;

  int tests_run = 0;
  int tests_failed = 0;

  kanagawa_sim_stall_monitor_if #(.COUNT_WIDTH(16)) if0 ();
  kanagawa_sim_stall_monitor_if #(.COUNT_WIDTH(16)) if1 ();
  kanagawa_sim_stall_monitor_if #(.COUNT_WIDTH(4))  if2 ();

  assign if0.stalled_in = stall;
  assign if1.stalled_in = stall;
  assign if2.stalled_in = stall;

  logic [15:0] burst0, sc0, max0;
  logic        de0, ie0;
  logic [15:0] burst1, sc1, max1;
  logic        de1, ie1;
  logic [3:0]  burst2, sc2, max2;
  logic        de2, ie2;

  kanagawa_sim_stall_monitor u0 (
    .clk(clk), .rst(rst), .enable(en), .clear(clr), .stall_if(if0.slave),
    .burst_count(burst0), .stall_cycles(sc0), .max_duration_seen(max0),
    .duration_err(de0), .interval_err(ie0)
  );

  kanagawa_sim_stall_monitor #(
    .COUNT_WIDTH(16), .MIN_DURATION(1), .MAX_DURATION(8),
    .MIN_INTERVAL(3), .MAX_INTERVAL(1024)
  ) u1 (
    .clk(clk), .rst(rst), .enable(en), .clear(clr), .stall_if(if1.slave),
    .burst_count(burst1), .stall_cycles(sc1), .max_duration_seen(max1),
    .duration_err(de1), .interval_err(ie1)
  );

  kanagawa_sim_stall_monitor #(
    .COUNT_WIDTH(4), .MIN_DURATION(1), .MAX_DURATION(100),
    .MIN_INTERVAL(1), .MAX_INTERVAL(1024)
  ) u2 (
    .clk(clk), .rst(rst), .enable(en), .clear(clr), .stall_if(if2.slave),
    .burst_count(burst2), .stall_cycles(sc2), .max_duration_seen(max2),
    .duration_err(de2), .interval_err(ie2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        exp_valid;
    logic        exp_is_stall;
    logic [15:0] exp_len;
    logic [15:0] exp_burst;
    logic [15:0] exp_sc;
    logic [15:0] exp_max;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic s, input logic v, input logic is,
                              input int len, input int b, input int sc, input int mx);
    vec_t r;
    r.stall        = s;
    r.exp_valid    = v;
    r.exp_is_stall = is;
    r.exp_len      = 16'(len);
    r.exp_burst    = 16'(b);
    r.exp_sc       = 16'(sc);
    r.exp_max      = 16'(mx);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one sample, let the edge take it, then look just after the edge.
  task automatic step(input logic s, input logic e, input logic c);
    stall = s;
    en    = e;
    clr   = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    stall = 1'b0;

    // ---- reset state of every instance
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst0_outputs", 32'(|{if0.run_valid, if0.run_is_stall, if0.run_len,
                               burst0, sc0, max0, de0, ie0}), 32'd0);
    check("rst1_outputs", 32'(|{if1.run_valid, if1.run_is_stall, if1.run_len,
                               burst1, sc1, max1, de1, ie1}), 32'd0);
    check("rst2_outputs", 32'(|{if2.run_valid, if2.run_is_stall, if2.run_len,
                               burst2, sc2, max2, de2, ie2}), 32'd0);

    // ---- asynchronous reset mid-burst, then a partial stall after release
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    check("pre_async_sc", 32'(sc0), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async_rst_outputs", 32'(|{if0.run_valid, if0.run_is_stall, if0.run_len,
                                    burst0, sc0, max0, de0, ie0}), 32'd0);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check("post_rst_no_pulse", 32'(if0.run_valid), 32'd0);
    end
    check("post_rst_sc", 32'(sc0), 32'd3);

    // ---- table: 0x3, 1x4, 0x5, 1x2, 0x2 on default bounds
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 1, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 2, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 3, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 4, 0);
    vecs[7]  = mk(0, 1, 1, 4, 1, 4, 4);
    vecs[8]  = mk(0, 0, 0, 0, 1, 4, 4);
    vecs[9]  = mk(0, 0, 0, 0, 1, 4, 4);
    vecs[10] = mk(0, 0, 0, 0, 1, 4, 4);
    vecs[11] = mk(0, 0, 0, 0, 1, 4, 4);
    vecs[12] = mk(1, 1, 0, 5, 1, 5, 4);
    vecs[13] = mk(1, 0, 0, 0, 1, 6, 4);
    vecs[14] = mk(0, 1, 1, 2, 2, 6, 4);
    vecs[15] = mk(0, 0, 0, 0, 2, 6, 4);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].stall, 1'b1, 1'b0);
      check($sformatf("tbl%0d_valid", i), 32'(if0.run_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("tbl%0d_is_stall", i), 32'(if0.run_is_stall), 32'(vecs[i].exp_is_stall));
        check($sformatf("tbl%0d_len", i), 32'(if0.run_len), 32'(vecs[i].exp_len));
      end
      check($sformatf("tbl%0d_burst", i), 32'(burst0), 32'(vecs[i].exp_burst));
      check($sformatf("tbl%0d_sc", i), 32'(sc0), 32'(vecs[i].exp_sc));
      check($sformatf("tbl%0d_max", i), 32'(max0), 32'(vecs[i].exp_max));
    end
    check("tbl_errs", 32'({de0, ie0}), 32'd0);

    // ---- duration overrun on u1 (MAX_DURATION=8): flagged at 9th stalled sample
    step(1'b0, 1'b1, 1'b1);
    check("c_clear_de", 32'(de1), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 8) check("c_de_before", 32'(de1), 32'd0);
      if (i == 9) check("c_de_at_9", 32'(de1), 32'd1);
    end
    step(1'b0, 1'b1, 1'b0);
    check("c_valid", 32'(if1.run_valid), 32'd1);
    check("c_is_stall", 32'(if1.run_is_stall), 32'd1);
    check("c_len", 32'(if1.run_len), 32'd12);
    check("c_de_sticky", 32'(de1), 32'd1);
    check("c_burst", 32'(burst1), 32'd1);

    // ---- short free run on u1 (MIN_INTERVAL=3): 0,1,1,0,0,1,0
    step(1'b0, 1'b1, 1'b1);
    check("d_clear_errs", 32'({de1, ie1}), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("d_p1", 32'({if1.run_valid, if1.run_is_stall, if1.run_len}), {15'd0, 1'b1, 1'b1, 16'd2});
    check("d_ie_p1", 32'(ie1), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    check("d_gap_valid", 32'(if1.run_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("d_p2", 32'({if1.run_valid, if1.run_is_stall, if1.run_len}), {15'd0, 1'b1, 1'b0, 16'd2});
    check("d_ie_p2", 32'(ie1), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check("d_p3", 32'({if1.run_valid, if1.run_is_stall, if1.run_len}), {15'd0, 1'b1, 1'b1, 16'd1});
    check("d_de", 32'(de1), 32'd0);

    // ---- saturation on u2 (COUNT_WIDTH=4): 20 stalled cycles report as 15
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("e_p", 32'({if2.run_valid, if2.run_is_stall, if2.run_len}), {26'd0, 1'b1, 1'b1, 4'd15});
    check("e_sc", 32'(sc2), 32'd15);
    check("e_max", 32'(max2), 32'd15);
    check("e_burst", 32'(burst2), 32'd1);
    check("e_de", 32'(de2), 32'd0);

    // ---- enable drop, partial after re-enable, clear coincident with completion
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("f_dis_valid", 32'(if0.run_valid), 32'd0);
    check("f_dis_sc", 32'(sc0), 32'd3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("f_partial_valid", 32'(if0.run_valid), 32'd0);
    check("f_partial_sc", 32'(sc0), 32'd8);
    check("f_partial_burst", 32'(burst0), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("f_free1", 32'({if0.run_valid, if0.run_is_stall, if0.run_len}), {15'd0, 1'b1, 1'b0, 16'd1});
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("f_clr_valid", 32'(if0.run_valid), 32'd0);
    check("f_clr_stats", 32'({burst0, sc0}), 32'd0);
    check("f_clr_max", 32'(max0), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("f_after_valid", 32'(if0.run_valid), 32'd0);
    check("f_after_sc", 32'(sc0), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check("f_after_partial", 32'(if0.run_valid), 32'd0);
    check("f_after_burst", 32'(burst0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/kanagawa_sim_stall_monitor.md
Name: kanagawa_sim_stall_monitor

Overview:
- Simulation-only checker at the consuming end of a generated stall line, such as a staller's stalled output or a stall-qualified ready.
- Samples the stall line every cycle and splits it into runs: stalled runs (bursts) and free runs (intervals).
- Reports each completed run, keeps saturating statistics, and raises sticky errors when run lengths leave the configured policy bounds.
- Sits in testbenches beside the stall generator, to confirm the stall policy the DUT actually receives.

Parameters:
- COUNT_WIDTH, 16: width of every length and statistic counter (min 2).
- MIN_DURATION, 1: minimum legal length of a completed stalled run.
- MAX_DURATION, 64: maximum legal length of a stalled run.
- MIN_INTERVAL, 1: minimum legal length of a completed free run.
- MAX_INTERVAL, 1024: maximum legal length of a free run.

Ports:
- clk  in  1  clock; all sampling on posedge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- enable  in  1  monitoring active; low forces IDLE.
- clear  in  1  synchronous clear of statistics, errors and run tracking.
- stalled_in  in  1  observed stall line; 1 = stalled.
- run_valid  out  1  one-cycle pulse: a checked run completed.
- run_is_stall  out  1  qualifies run_valid: 1 = stalled run, 0 = free run.
- run_len  out  COUNT_WIDTH  length of the completed run, in cycles.
- burst_count  out  COUNT_WIDTH  completed checked stalled runs.
- stall_cycles  out  COUNT_WIDTH  total cycles stalled_in==1 sampled while enabled.
- max_duration_seen  out  COUNT_WIDTH  longest completed checked stalled run.
- duration_err  out  1  sticky: stalled-run bound violated.
- interval_err  out  1  sticky: free-run bound violated.

Behaviour:
- Reset (rst==0, async): state=IDLE, cur_len=0, every output 0.
- State machine:
  - IDLE: the next enabled sample loads cur_len=1 and enters STALL_PARTIAL or FREE_PARTIAL according to stalled_in.
  - PARTIAL → full: when the sample differs from the current level, the partial run ends, cur_len=1, and the state becomes STALL_FULL or FREE_FULL.
  - FULL → FULL: a level change completes the run and enters the opposite FULL state with cur_len=1.
  - Same level in any run state: cur_len increments.
- PARTIAL runs have an unknown start. They are never reported and never min-checked.
- Completion (FULL runs only), on the edge that first samples the new level:
  - Registered outputs: run_valid=1 for exactly one cycle, run_is_stall=previous level, run_len=cur_len.
  - Stalled run: burst_count increments, max_duration_seen updates, and if run_len<MIN_DURATION then duration_err is set.
  - Free run: if run_len<MIN_INTERVAL then interval_err is set.
- Overrun checks apply in PARTIAL and FULL states:
  - duration_err is set on the edge where the stalled cur_len would become MAX_DURATION+1.
  - interval_err is set on the edge where the free cur_len would become MAX_INTERVAL+1.
  - The error is flagged immediately, not at run end.
- stall_cycles increments on every enabled sample with stalled_in==1, in any state, including the sample taken from IDLE.
- Saturation: cur_len and all statistics saturate at 2^COUNT_WIDTH-1 and never wrap. Overrun detection uses the unsaturated comparison: a bound ≥ 2^COUNT_WIDTH-1 is never flagged.
- enable=0: state=IDLE, cur_len=0, run_valid=0. Statistics and errors hold. A run interrupted by enable dropping is not reported.
- clear=1 takes priority over enable and over a completion in the same cycle:
  - Statistics and errors are zeroed, run_valid=0, state=IDLE.
  - The completing run is discarded, and the next run is PARTIAL.
- Errors stay set until clear or reset.

Test Plan:
- rst=0 pulse mid-burst with no clock edge → all outputs 0 asynchronously. After release with enable=1 and stalled_in=1 for 3 cycles → run_valid never pulses, stall_cycles=3.
- enable=1, stalled_in 0×3, 1×4, 0×5, 1×2, 0… → pulse (stall,4), then (free,5), then (stall,2); burst_count=2, max_duration_seen=4, stall_cycles=6, no errors.
- MAX_DURATION=8, after one free sample, stall held 12 cycles → duration_err rises at the edge sampling the 9th stalled cycle; later pulse (stall,12); duration_err stays 1.
- MIN_INTERVAL=3, sequence 0,1,1,0,0,1,0 → pulse (stall,2), then (free,2) with interval_err=1 on that same edge.
- COUNT_WIDTH=4, MAX_DURATION=100, stall 20 cycles bracketed by free cycles → run_len=15, stall_cycles=15, duration_err=0.
- Stall 3 cycles then enable=0 → no pulse. Re-enable with stalled_in high for 5 cycles then low → no pulse (partial), stall_cycles+=5. Assert clear coincident with a completion → run_valid=0, all stats 0.
